// File: rtl/tran_shifter.sv
// tran_shifter: registered 8-bit bidirectional shifter with one-hot magnitude select.
// Select codes (shift_mag[0] is MSB): 10000 right-2, 01000 right-1, 00100 pass,
// 00010 left-1, 00001 left-2. "Left" moves bits toward index 0 (the MSB).
// Any select that is not exactly one-hot forces Op to zero and raises err.
// Optional build macro TRAN_SHIFTER_ROTATE_EN: shifts rotate instead of zero-filling.
module tran_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] Ip,
  input  logic [0:4] shift_mag,
  output logic [0:7] Op,
  output logic       err
);

  // Per-magnitude network outputs, one per transmission-gate column.
  logic [0:7] right2_s;
  logic [0:7] right1_s;
  logic [0:7] pass_s;
  logic [0:7] left1_s;
  logic [0:7] left2_s;

  logic [0:7] op_d;
  logic       err_d;
  logic [0:7] op_q;
  logic       err_q;

`ifdef TRAN_SHIFTER_ROTATE_EN
  // Rotating columns: bits leaving one end re-enter at the other end.
  always_comb begin
    right2_s = {Ip[6:7], Ip[0:5]};
    right1_s = {Ip[7],   Ip[0:6]};
    pass_s   = Ip;
    left1_s  = {Ip[1:7], Ip[0]};
    left2_s  = {Ip[2:7], Ip[0:1]};
  end
`else
  // Logical columns: vacated positions are zero-filled, no sign extension.
  always_comb begin
    right2_s = {2'b00, Ip[0:5]};
    right1_s = {1'b0,  Ip[0:6]};
    pass_s   = Ip;
    left1_s  = {Ip[1:7], 1'b0};
    left2_s  = {Ip[2:7], 2'b00};
  end
`endif

  // Select exactly one column; all-zero or multi-hot selects are illegal.
  always_comb begin
    op_d  = 8'h00;
    err_d = 1'b1;
    case (shift_mag)
      5'b10000: begin
        op_d  = right2_s;
        err_d = 1'b0;
      end
      5'b01000: begin
        op_d  = right1_s;
        err_d = 1'b0;
      end
      5'b00100: begin
        op_d  = pass_s;
        err_d = 1'b0;
      end
      5'b00010: begin
        op_d  = left1_s;
        err_d = 1'b0;
      end
      5'b00001: begin
        op_d  = left2_s;
        err_d = 1'b0;
      end
      default: begin
        op_d  = 8'h00;
        err_d = 1'b1;
      end
    endcase
  end

  // Output register: captures every cycle, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 8'h00;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      err_q <= err_d;
    end
  end

  assign Op  = op_q;
  assign err = err_q;

endmodule

// File: tb/tb_tran_shifter.sv
// Directed self-checking bench for tran_shifter.
module tb_tran_shifter;

  logic       clk;
  logic       rst;
  logic [0:7] Ip;
  logic [0:4] shift_mag;
  logic [0:7] Op;
  logic       err;

  int n_checks;
  int n_errors;

  tran_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .Ip        (Ip),
    .shift_mag (shift_mag),
    .Op        (Op),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic apply(input logic [7:0] ip_v, input logic [4:0] sel_v);
    @(negedge clk);
    Ip        = ip_v;
    shift_mag = sel_v;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input string tag, input logic [7:0] ip_v, input logic [4:0] sel_v,
                             input logic [7:0] exp_op, input logic exp_err);
    apply(ip_v, sel_v);
    check({tag, ".op"}, Op, exp_op);
    check({tag, ".err"}, {7'd0, err}, {7'd0, exp_err});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    Ip        = 8'hFF;
    shift_mag = 5'b00100;

    // Reset value before any clock edge.
    #3;
    check("rst_async.op", Op, 8'h00);
    check("rst_async.err", {7'd0, err}, 8'h00);

    // Held through clock edges while rst stays high.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold.op", Op, 8'h00);

    // First edge after release captures current inputs.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.op", Op, 8'hFF);
    check("post_rst.err", {7'd0, err}, 8'h00);

    apply_check("pass_01", 8'h01, 5'b00100, 8'h01, 1'b0);

    // One-cycle latency: output unchanged until the edge.
    @(negedge clk);
    Ip        = 8'h01;
    shift_mag = 5'b00010;
    #1;
    check("latency.op", Op, 8'h01);
    @(posedge clk);
    #1;
    check("left1_01.op", Op, 8'h02);

`ifdef TRAN_SHIFTER_ROTATE_EN
    apply_check("left2_AD",  8'hAD, 5'b00001, 8'hB6, 1'b0);
    apply_check("right2_AD", 8'hAD, 5'b10000, 8'h6B, 1'b0);
    apply_check("right1_81", 8'h81, 5'b01000, 8'hC0, 1'b0);
    apply_check("left1_81",  8'h81, 5'b00010, 8'h03, 1'b0);
`else
    apply_check("left2_AD",  8'hAD, 5'b00001, 8'hB4, 1'b0);
    apply_check("right2_AD", 8'hAD, 5'b10000, 8'h2B, 1'b0);
    apply_check("right1_81", 8'h81, 5'b01000, 8'h40, 1'b0);
    apply_check("left1_81",  8'h81, 5'b00010, 8'h02, 1'b0);
`endif
    apply_check("pass_AD",   8'hAD, 5'b00100, 8'hAD, 1'b0);

    // Illegal selects, then recovery on a legal one.
    apply_check("ill_zero",  8'hAD, 5'b00000, 8'h00, 1'b1);
    apply_check("ill_multi", 8'hAD, 5'b00110, 8'h00, 1'b1);
    apply_check("ill_all",   8'h5A, 5'b11111, 8'h00, 1'b1);
    apply_check("recover",   8'hAD, 5'b00100, 8'hAD, 1'b0);
    apply_check("ill_again", 8'h3C, 5'b10001, 8'h00, 1'b1);

    // Mid-stream asynchronous reset clears between edges.
    apply_check("pre_rst2", 8'h3C, 5'b00100, 8'h3C, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.op", Op, 8'h00);
    @(negedge clk);
    rst       = 1'b0;
    Ip        = 8'hC3;
    shift_mag = 5'b01000;
    @(posedge clk);
    #1;
`ifdef TRAN_SHIFTER_ROTATE_EN
    check("post_rst2.op", Op, 8'hE1);
`else
    check("post_rst2.op", Op, 8'h61);
`endif
    check("post_rst2.err", {7'd0, err}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
